// File: rtl/mdu.sv
// Multiply/divide unit for the Execute stage: owns HI/LO, precomputes the
// 64-bit result on accept and commits it after a fixed busy latency.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [1:0]  MDU_Sel,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        HI_En,
  input  logic        LO_En,
  input  logic        MDU_Out_Sel,
  input  logic        Req,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDU_Out
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] count_reg, count_next;
  logic [31:0]   hi_reg, lo_reg;
  logic [31:0]   pend_hi_reg, pend_lo_reg;
  logic          pend_wr_reg;

  logic          accept, mt_ok, commit;
  logic          is_div, is_signed, div_zero;
  logic          a_neg, b_neg;
  logic [63:0]   ext_a, ext_b, prod;
  logic [31:0]   mag_a, mag_b, uq, ur, quo, rem;
  logic [31:0]   res_hi, res_lo;
  logic          res_wr;

  assign Busy    = (state_reg == RUN);
  assign HI      = hi_reg;
  assign LO      = lo_reg;
  assign MDU_Out = MDU_Out_Sel ? lo_reg : hi_reg;

  // Start always takes priority over an MTHI/MTLO in the same cycle.
  assign accept = Start & ~Req & ~Busy;
  assign mt_ok  = ~Start & ~Req & ~Busy;

  // Result datapath, evaluated from the live operands at the accept edge.
  always_comb begin
    is_div    = MDU_Sel[1];
    is_signed = ~MDU_Sel[0];
    div_zero  = (B == 32'd0);

    ext_a = {{32{is_signed & A[31]}}, A};
    ext_b = {{32{is_signed & B[31]}}, B};
    prod  = ext_a * ext_b;

    // Divide on magnitudes so INT_MIN / -1 wraps to INT_MIN without overflow.
    a_neg = is_signed & A[31];
    b_neg = is_signed & B[31];
    mag_a = a_neg ? (~A + 32'd1) : A;
    mag_b = b_neg ? (~B + 32'd1) : B;
    if (div_zero) begin
      uq = 32'd0;
      ur = 32'd0;
    end else begin
      uq = mag_a / mag_b;
      ur = mag_a % mag_b;
    end
    quo = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
    rem = a_neg ? (~ur + 32'd1) : ur;

    if (is_div) begin
      res_hi = rem;
      res_lo = quo;
      res_wr = ~div_zero;
    end else begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
      res_wr = 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    commit     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = RUN;
          count_next = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end
      end
      RUN: begin
        count_next = count_reg - CW'(1);
        if (count_reg == CW'(1)) begin
          commit     = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_hi_reg <= 32'd0;
      pend_lo_reg <= 32'd0;
      pend_wr_reg <= 1'b0;
    end else if (accept) begin
      pend_hi_reg <= res_hi;
      pend_lo_reg <= res_lo;
      pend_wr_reg <= res_wr;
    end
  end

  // commit only happens while Busy, so it never collides with an MT write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_reg <= 32'd0;
      lo_reg <= 32'd0;
    end else if (commit) begin
      if (pend_wr_reg) begin
        hi_reg <= pend_hi_reg;
        lo_reg <= pend_lo_reg;
      end
    end else if (mt_ok) begin
      if (HI_En) hi_reg <= A;
      if (LO_En) lo_reg <= A;
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed table, hand sequences for the
// multi-cycle corners, and random operations against a plain-arithmetic model.
module tb_mdu;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk;
  logic        reset;
  logic        Start;
  logic [1:0]  MDU_Sel;
  logic [31:0] A, B;
  logic        HI_En, LO_En, MDU_Out_Sel, Req;
  logic        Busy;
  logic [31:0] HI, LO, MDU_Out;

  mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MDU_Sel(MDU_Sel),
    .A(A), .B(B), .HI_En(HI_En), .LO_En(LO_En),
    .MDU_Out_Sel(MDU_Out_Sel), .Req(Req),
    .Busy(Busy), .HI(HI), .LO(LO), .MDU_Out(MDU_Out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t        tbl[8];
  int          vectors;
  int          miscompares;
  logic [31:0] hi_m, lo_m;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Architectural reference: plain 64-bit arithmetic on the operands.
  task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       inout logic [31:0] hi, inout logic [31:0] lo);
    longint      sa, sb, sq, sr;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'd0: begin
        sq = sa * sb;
        hi = sq[63:32];
        lo = sq[31:0];
      end
      2'd1: begin
        up = {32'd0, a} * {32'd0, b};
        hi = up[63:32];
        lo = up[31:0];
      end
      2'd2: if (b != 0) begin
        sq = sa / sb;
        sr = sa % sb;
        lo = sq[31:0];
        hi = sr[31:0];
      end
      default: if (b != 0) begin
        lo = a / b;
        hi = a % b;
      end
    endcase
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_hi"}, HI, hi_m);
    check({tag, "_lo"}, LO, lo_m);
    MDU_Out_Sel = 1'b0;
    #1 check({tag, "_out_hi"}, MDU_Out, hi_m);
    MDU_Out_Sel = 1'b1;
    #1 check({tag, "_out_lo"}, MDU_Out, lo_m);
  endtask

  task automatic mt(input logic he, input logic le, input logic [31:0] val);
    HI_En = he; LO_En = le; A = val;
    tick();
    HI_En = 1'b0; LO_En = 1'b0; A = $urandom;
    if (he) hi_m = val;
    if (le) lo_m = val;
    check("mt_busy", Busy, 1'b0);
    check_regs("mt");
    $display("MT   hi_en=%0b lo_en=%0b val=%h -> HI=%h LO=%h", he, le, val, HI, LO);
  endtask

  // noise: hammer Start/HI_En/LO_En/Req while busy; with_wr: MT alongside Start.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit noise, input bit with_wr);
    int n;
    int exp_n;
    Start = 1'b1; MDU_Sel = op; A = a; B = b;
    HI_En = with_wr; LO_En = with_wr;
    tick();
    Start = 1'b0; HI_En = 1'b0; LO_En = 1'b0; A = $urandom; B = $urandom;
    exp_n = op[1] ? DIV_N : MULT_N;
    n = 0;
    while (Busy === 1'b1 && n < 200) begin
      n++;
      if (noise) begin
        Start = 1'($urandom); HI_En = 1'b1; LO_En = 1'($urandom);
        Req = 1'($urandom); MDU_Sel = 2'($urandom); A = $urandom;
      end
      tick();
    end
    Start = 1'b0; HI_En = 1'b0; LO_En = 1'b0; Req = 1'b0;
    model(op, a, b, hi_m, lo_m);
    check("busy_cycles", 64'(n), 64'(exp_n));
    check_regs("op");
    $display("OP   sel=%0d a=%h b=%h busy=%0d -> HI=%h LO=%h", op, a, b, n, HI, LO);
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    hi_m = 32'd0; lo_m = 32'd0;
    reset = 1'b1; Start = 1'b0; MDU_Sel = 2'd0; A = 32'd0; B = 32'd0;
    HI_En = 1'b0; LO_En = 1'b0; MDU_Out_Sel = 1'b0; Req = 1'b0;

    tbl[0] = '{2'd0, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA};
    tbl[1] = '{2'd1, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA};
    tbl[2] = '{2'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    tbl[3] = '{2'd3, 32'd7,        32'd2,        32'h00000001, 32'h00000003};
    tbl[4] = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    tbl[5] = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    tbl[6] = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    tbl[7] = '{2'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};

    repeat (3) tick();
    check("reset_busy", Busy, 1'b0);
    check_regs("reset");
    reset = 1'b0;
    tick();

    // MTLO then MFLO
    mt(1'b0, 1'b1, 32'h12345678);

    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, 1'b0, 1'b0);
      check("tbl_hi", HI, tbl[i].hi);
      check("tbl_lo", LO, tbl[i].lo);
    end

    // Divide by zero leaves HI/LO alone; the MT issued with Start is dropped.
    mt(1'b1, 1'b0, 32'hAAAA0000);
    mt(1'b0, 1'b1, 32'h00005555);
    run_op(2'd3, 32'd1234, 32'd0, 1'b0, 1'b1);
    check("div0_hi", HI, 32'hAAAA0000);
    check("div0_lo", LO, 32'h00005555);
    run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);

    // Start and MT writes squashed by Req
    Start = 1'b1; Req = 1'b1; MDU_Sel = 2'd1; A = 32'h11111111; B = 32'd9;
    tick();
    Start = 1'b0; HI_En = 1'b1; LO_En = 1'b1;
    check("req_busy", Busy, 1'b0);
    tick();
    HI_En = 1'b0; LO_En = 1'b0; Req = 1'b0;
    check("req_busy2", Busy, 1'b0);
    check_regs("req");

    // Req, Start and writes while busy must not disturb the operation
    run_op(2'd0, 32'hDEADBEEF, 32'h00C0FFEE, 1'b1, 1'b0);
    run_op(2'd2, 32'h8765ABCD, 32'h00001234, 1'b1, 1'b0);

    // Reset in the third busy cycle of a MULT
    mt(1'b1, 1'b1, 32'hCAFEF00D);
    Start = 1'b1; MDU_Sel = 2'd0; A = 32'd100; B = 32'd200;
    tick();
    Start = 1'b0;
    tick(); tick();
    check("pre_reset_busy", Busy, 1'b1);
    reset = 1'b1;
    #1;
    hi_m = 32'd0; lo_m = 32'd0;
    check("rst_busy", Busy, 1'b0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    #1 reset = 1'b0;
    tick();
    check("post_rst_busy", Busy, 1'b0);
    check_regs("post_rst");
    run_op(2'd0, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0);

    // Random operations and moves against the model
    for (int i = 0; i < 40; i++) begin
      int          r;
      logic [31:0] ra, rb;
      r  = $urandom_range(0, 9);
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
      if (r < 2)
        mt(1'($urandom), 1'($urandom), ra);
      else
        run_op(2'($urandom), ra, rb, 1'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
